irq_arbiter: RTL

Multi-source interrupt controller that sits in front of the core's single external interrupt input. It synchronises N asynchronous interrupt lines, latches or tracks them per configuration, and masks them. It selects one source by round-robin and drives the core's `interrupter` line. It then holds the grant through the service window until the handler signals end-of-interrupt, so CP0 sees one well-formed request at a time and software can read which source is being served.

---
 rtl/irq_arbiter_pkg.sv | 14 +
 rtl/irq_arbiter_rr_pick.sv | 35 +++
 rtl/irq_arbiter.sv | 128 ++++++++++++
 3 files changed

// File: rtl/irq_arbiter_pkg.sv
// Shared state encoding and configuration register addresses for the interrupt arbiter.
package irq_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StReq     = 2'd1,
    StService = 2'd2
  } state_e;

  localparam logic [1:0] CfgMask = 2'd0;
  localparam logic [1:0] CfgEdge = 2'd1;
  localparam logic [1:0] CfgPclr = 2'd2;

endpackage

// File: rtl/irq_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request at or after ptr, wrapping modulo N.
module irq_arbiter_rr_pick #(
  parameter int unsigned N    = 8,
  parameter int unsigned ID_W = 3
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [ID_W-1:0] gnt_id,
  output logic            any
);

  logic [N-1:0] w_rot;
  int unsigned  w_off;

  // Rotate so that bit 0 is the request at ptr; the scan then becomes a plain priority search.
  assign w_rot = N'({req, req} >> ptr);

  always_comb begin
    any    = 1'b0;
    w_off  = 0;
    gnt_id = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (!any && w_rot[k]) begin
        any   = 1'b1;
        w_off = k;
      end
    end
    w_off = 32'(ptr) + w_off;
    if (w_off >= N) begin
      w_off = w_off - N;
    end
    gnt_id = ID_W'(w_off);
  end

endmodule

// File: rtl/irq_arbiter.sv
// Multi-source interrupt controller: synchronises, latches or tracks, masks and round-robins
// N lines onto one core request, holding the grant until end-of-interrupt.
module irq_arbiter #(
  parameter int unsigned N_SRC = 8,
  parameter int unsigned ID_W  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] irq_src,
  input  logic             cfg_wen,
  input  logic [1:0]       cfg_addr,
  input  logic [31:0]      cfg_wdata,
  input  logic             irq_ack,
  input  logic             irq_eoi,
  output logic             interrupter,
  output logic [ID_W-1:0]  irq_id,
  output logic             irq_active,
  output logic [N_SRC-1:0] pending
);

  import irq_arbiter_pkg::*;

  logic [N_SRC-1:0] r_s1, r_s2, r_s3;
  logic [N_SRC-1:0] r_pend, r_mask, r_edge;
  logic [ID_W-1:0]  r_id, r_rr;
  state_e           r_state;

  state_e           w_state_d;
  logic [ID_W-1:0]  w_id_d, w_rr_d, w_pick;
  logic             w_any, w_eoi_fire, w_unused_wdata;
  logic [N_SRC-1:0] w_wdata, w_elig, w_set, w_clr, w_pend_d;

  assign w_wdata        = cfg_wdata[N_SRC-1:0];
  assign w_unused_wdata = ^cfg_wdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1 <= '0;
      r_s2 <= '0;
      r_s3 <= '0;
    end else begin
      r_s1 <= irq_src;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mask <= '1;
      r_edge <= '0;
    end else if (cfg_wen) begin
      if (cfg_addr == CfgMask) r_mask <= w_wdata;
      if (cfg_addr == CfgEdge) r_edge <= w_wdata;
    end
  end

  // Edge bits latch with set-over-clear priority; level bits simply follow the synchroniser.
  assign w_eoi_fire = (r_state == StService) && irq_eoi;
  assign w_set      = r_s2 & ~r_s3;
  assign w_clr      = ((cfg_wen && cfg_addr == CfgPclr) ? w_wdata : '0)
                    | (w_eoi_fire ? (N_SRC'(1) << r_id) : '0);
  assign w_pend_d   = (r_edge & (w_set | (r_pend & ~w_clr))) | (~r_edge & r_s2);
  assign w_elig     = r_pend & ~r_mask;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pend <= '0;
    end else begin
      r_pend <= w_pend_d;
    end
  end

  irq_arbiter_rr_pick #(
    .N    (N_SRC),
    .ID_W (ID_W)
  ) u_rr_pick (
    .req    (w_elig),
    .ptr    (r_rr),
    .gnt_id (w_pick),
    .any    (w_any)
  );

  always_comb begin
    w_state_d = r_state;
    w_id_d    = r_id;
    w_rr_d    = r_rr;
    case (r_state)
      StIdle: begin
        if (w_any) begin
          w_state_d = StReq;
          w_id_d    = w_pick;
        end
      end
      StReq: begin
        // Ack wins over a simultaneous withdrawal: the core has already taken the interrupt.
        if (irq_ack) begin
          w_state_d = StService;
          w_rr_d    = (r_id == ID_W'(N_SRC - 1)) ? '0 : r_id + ID_W'(1);
        end else if (!w_elig[r_id]) begin
          w_state_d = StIdle;
        end
      end
      StService: begin
        if (irq_eoi) w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= StIdle;
      r_id    <= '0;
      r_rr    <= '0;
    end else begin
      r_state <= w_state_d;
      r_id    <= w_id_d;
      r_rr    <= w_rr_d;
    end
  end

  assign interrupter = (r_state == StReq);
  assign irq_active  = (r_state == StService);
  assign irq_id      = r_id;
  assign pending     = r_pend;

endmodule
